pipe_hazard_ctrl: RTL and testbench

//  Pipeline control for the 5-stage CPU; drives the ID/EX register's en_reg and sync clear (flush) plus IF/ID and PC enables.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_mdu_wait_counter.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline hazard controller.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, the architectural zero register index and the
// default mult/div occupancy in EX.
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } state_t;

   localparam logic [4:0] REG_ZERO    = 5'd0;
   localparam int         MDU_LAT_DEF = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_wait_counter.sv
// Load/decrement down-counter with zero flag, times the mult/div stall.
// Latency: load and decrement take effect on the next rising edge.
// Backpressure: none; i_load has priority over i_dec.
//
// Ports:
//   clk, rst            clock, async active-low reset (counter -> 0)
//   i_load, i_load_val  load a start value
//   i_dec               decrement by one (ignored when already zero)
//   o_zero              counter currently equals zero
module mdu_wait_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for the 5-stage CPU: load-use bubbles, branch/jump flushes, mult/div freeze.
// Latency: outputs are combinational from the current state and inputs (zero cycles).
// Backpressure: drops pc/IF-ID/ID-EX enables to stall; flushes override enables downstream.
//
// Optional feature macro: HAZ_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
//
// Ports:
//   clk, rst                      clock, async active-low reset (all outputs 0 while low)
//   id_rs, id_rt, id_uses_rt      source registers of the instruction in ID
//   id_jump                       jump resolved in ID
//   ex_MemRead, ex_rt             load currently in EX and its destination
//   ex_branch_taken               branch in EX resolved taken
//   ex_mdu_start                  first EX cycle of a mult/div
//   pc_en, ifid_en, idex_en       stage enables
//   ifid_flush, idex_flush        synchronous stage clears
//   exmem_bubble                  EX/MEM loads a NOP
//   mdu_busy, mdu_done            mult/div wait state and completion pulse
//   stall_cnt, flush_cnt          perf counters (HAZ_PERF_CNT_EN only)
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MDU_LAT = MDU_LAT_DEF
`ifdef HAZ_PERF_CNT_EN
   ,
   parameter int CNT_W   = 16
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_jump,
   input  logic             ex_MemRead,
   input  logic [4:0]       ex_rt,
   input  logic             ex_branch_taken,
   input  logic             ex_mdu_start,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_bubble,
   output logic             mdu_busy,
   output logic             mdu_done
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   localparam int            CW       = $clog2(MDU_LAT);
   // The start cycle and the final zero cycle are both part of the EX
   // occupancy, so the counter only needs MDU_LAT-2 wait steps in between.
   localparam logic [CW-1:0] LOAD_VAL = CW'(MDU_LAT - 2);

   state_t r_state;
   logic   w_load_use;
   logic   w_cnt_load;
   logic   w_cnt_dec;
   logic   w_cnt_zero;

   // Register 0 is hard-wired, so a load targeting it never creates a hazard.
   assign w_load_use = ex_MemRead && (ex_rt != REG_ZERO) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   always_comb begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b0;
      idex_en      = 1'b0;
      idex_flush   = 1'b0;
      exmem_bubble = 1'b0;
      mdu_busy     = 1'b0;
      mdu_done     = 1'b0;
      w_cnt_load   = 1'b0;
      if (rst) begin
         case (r_state)
            RUN: begin
               if (ex_branch_taken) begin
                  pc_en      = 1'b1;
                  ifid_en    = 1'b1;
                  ifid_flush = 1'b1;
                  idex_en    = 1'b1;
                  idex_flush = 1'b1;
               end else if (ex_mdu_start) begin
                  exmem_bubble = 1'b1;
                  w_cnt_load   = 1'b1;
               end else if (w_load_use) begin
                  // Hold PC and IF/ID; ID/EX takes a bubble so the load
                  // drains from EX and the hazard clears next cycle.
                  idex_en    = 1'b1;
                  idex_flush = 1'b1;
               end else if (id_jump) begin
                  pc_en      = 1'b1;
                  ifid_en    = 1'b1;
                  ifid_flush = 1'b1;
                  idex_en    = 1'b1;
               end else begin
                  pc_en   = 1'b1;
                  ifid_en = 1'b1;
                  idex_en = 1'b1;
               end
            end
            MDU_WAIT: begin
               // EX is frozen on the mult/div; other hazards wait for RUN.
               mdu_busy = 1'b1;
               if (w_cnt_zero) begin
                  mdu_done = 1'b1;
                  pc_en    = 1'b1;
                  ifid_en  = 1'b1;
                  idex_en  = 1'b1;
               end else begin
                  exmem_bubble = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign w_cnt_dec = (r_state == MDU_WAIT) && !w_cnt_zero;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= RUN;
      end else begin
         case (r_state)
            RUN:      if (!ex_branch_taken && ex_mdu_start) r_state <= MDU_WAIT;
            MDU_WAIT: if (w_cnt_zero)                       r_state <= RUN;
            default:                                        r_state <= RUN;
         endcase
      end
   end

   mdu_wait_counter #(
      .W (CW)
   ) u_mdu_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_cnt_load),
      .i_load_val (LOAD_VAL),
      .i_dec      (w_cnt_dec),
      .o_zero     (w_cnt_zero)
   );

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // Saturating event counters; reset cycles are never counted because the
   // counters are held at zero while rst is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!pc_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (ifid_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl with MDU_LAT=4 (and CNT_W=2 when perf counters exist).
// Latency: inputs driven 1 time unit after posedge, outputs sampled at negedge.
// Backpressure: n/a.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, id_jump, ex_MemRead, ex_branch_taken, ex_mdu_start;
   logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
   logic       exmem_bubble, mdu_busy, mdu_done;
`ifdef HAZ_PERF_CNT_EN
   logic [1:0] stall_cnt, flush_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .MDU_LAT (4)
`ifdef HAZ_PERF_CNT_EN
      ,
      .CNT_W   (2)
`endif
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rt      (id_uses_rt),
      .id_jump         (id_jump),
      .ex_MemRead      (ex_MemRead),
      .ex_rt           (ex_rt),
      .ex_branch_taken (ex_branch_taken),
      .ex_mdu_start    (ex_mdu_start),
      .pc_en           (pc_en),
      .ifid_en         (ifid_en),
      .ifid_flush      (ifid_flush),
      .idex_en         (idex_en),
      .idex_flush      (idex_flush),
      .exmem_bubble    (exmem_bubble),
      .mdu_busy        (mdu_busy),
      .mdu_done        (mdu_done)
`ifdef HAZ_PERF_CNT_EN
      ,
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
`endif
   );

   // Output order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_bubble mdu_busy mdu_done
   localparam logic [7:0] O_ZERO = 8'b0000_0000;
   localparam logic [7:0] O_RUN  = 8'b1101_0000;
   localparam logic [7:0] O_LU   = 8'b0001_1000;
   localparam logic [7:0] O_JMP  = 8'b1111_0000;
   localparam logic [7:0] O_BR   = 8'b1111_1000;
   localparam logic [7:0] O_MST  = 8'b0000_0100;
   localparam logic [7:0] O_MWT  = 8'b0000_0110;
   localparam logic [7:0] O_MDN  = 8'b1101_0011;

   typedef struct {
      string      name;
      logic [4:0] rs, rt, xrt;
      logic       uses_rt, jump, memrd, br, mst;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic jump, input logic memrd, input logic [4:0] xrt,
                        input logic br, input logic mst);
      id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; id_jump = jump;
      ex_MemRead = memrd; ex_rt = xrt; ex_branch_taken = br; ex_mdu_start = mst;
   endtask

   task automatic idle();
      drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string name, input logic [7:0] exp);
      logic [7:0] act;
      act = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_bubble, mdu_busy, mdu_done};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%b exp=%b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", name, act, exp);
      end
   endtask

   // Advance to the next cycle's drive point.
   task automatic nxt();
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{"default",        5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
      vecs[1]  = '{"lu_rs",          5'd8, 5'd2, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_LU};
      vecs[2]  = '{"lu_cleared",     5'd8, 5'd2, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
      vecs[3]  = '{"lu_reg0",        5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_RUN};
      vecs[4]  = '{"lu_rt_unused",   5'd3, 5'd8, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_RUN};
      vecs[5]  = '{"lu_rt_used",     5'd3, 5'd8, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_LU};
      vecs[6]  = '{"jump",           5'd3, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_JMP};
      vecs[7]  = '{"lu_beats_jump",  5'd9, 5'd4, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_LU};
      vecs[8]  = '{"br_beats_lu",    5'd8, 5'd2, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, O_BR};
      vecs[9]  = '{"br_beats_jump",  5'd3, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_BR};
      vecs[10] = '{"br_beats_mdu",   5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_BR};
      vecs[11] = '{"after_br_mdu",   5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};

      // Reset state, with a load-use pattern present to prove outputs are gated.
      rst = 1'b0;
      drive(5'd8, 5'd2, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
      @(negedge clk); chk("reset_outputs", O_ZERO);
      nxt(); rst = 1'b1; idle();
      @(negedge clk); chk("post_reset_run", O_RUN);

      // Single-cycle RUN vectors.
      for (int i = 0; i < 12; i++) begin
         nxt();
         drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].jump,
               vecs[i].memrd, vecs[i].xrt, vecs[i].br, vecs[i].mst);
         @(negedge clk); chk(vecs[i].name, vecs[i].exp);
      end

      // Mult/div with MDU_LAT=4; a branch/jump/load-use is held during the
      // wait to show it is ignored until the FSM returns to RUN.
      nxt(); idle(); ex_mdu_start = 1'b1;
      @(negedge clk); chk("mdu_c1_start", O_MST);
      nxt(); drive(5'd8, 5'd2, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
      @(negedge clk); chk("mdu_c2_wait", O_MWT);
      nxt();
      @(negedge clk); chk("mdu_c3_wait", O_MWT);
      nxt();
      @(negedge clk); chk("mdu_c4_done", O_MDN);
      nxt();
      @(negedge clk); chk("mdu_back_run_br", O_BR);
      nxt(); idle();
      @(negedge clk); chk("mdu_idle", O_RUN);

      // Reset on the second MDU_WAIT cycle aborts the op.
      nxt(); ex_mdu_start = 1'b1;
      @(negedge clk); chk("abort_start", O_MST);
      nxt(); idle();
      @(negedge clk); chk("abort_wait1", O_MWT);
      nxt(); rst = 1'b0;
      @(negedge clk); chk("abort_in_reset", O_ZERO);
      nxt(); rst = 1'b1;
      @(negedge clk); chk("abort_released", O_RUN);
      nxt();
      @(negedge clk); chk("abort_no_done", O_RUN);

`ifdef HAZ_PERF_CNT_EN
      nxt(); rst = 1'b0;
      nxt(); rst = 1'b1;
      @(negedge clk);
      chk_int("perf_stall_reset", int'(stall_cnt), 0);
      chk_int("perf_flush_reset", int'(flush_cnt), 0);
      nxt(); drive(5'd8, 5'd2, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) nxt();
      idle();
      @(negedge clk);
      chk_int("perf_stall_sat", int'(stall_cnt), 3);
      chk_int("perf_flush_zero", int'(flush_cnt), 0);
      nxt(); id_jump = 1'b1;
      nxt(); nxt(); idle();
      @(negedge clk);
      chk_int("perf_flush_two", int'(flush_cnt), 2);
      chk_int("perf_stall_hold", int'(stall_cnt), 3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
